asi_rmem: RTL and testbench

// - User-clock read backend directly downstream of the AXI slave read interface user port.
// - Consumes the per-beat request m_re/m_raddr/m_rsize and drives a 1-port synchronous SRAM.
// - Returns m_rdata/m_rvalid/m_rslverr exactly SLV_WS cycles after each m_re, matching the upstream sideband delay line.
// - Zeroes unused byte lanes, range-checks addresses and keeps error status.

---
 rtl/asi_pkg.sv | 38 +++
 rtl/asi_rmem_pipe.sv | 43 ++++
 rtl/asi_rmem.sv | 182 ++++++++++++++++++
 tb/tb_asi_rmem.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/asi_pkg.sv
// Shared helpers for the ASI user-port backends: byte-lane masks and their bit expansion.
// Widths are sized for the widest supported beat; callers cast down to their own lane count.
package asi_pkg;

  localparam int unsigned MAX_BYTES = 128;
  localparam int unsigned MAX_LO_W  = 7;
  localparam int unsigned MAX_SZ_W  = 3;

  typedef logic [MAX_BYTES-1:0]   lane_mask_t;
  typedef logic [MAX_BYTES*8-1:0] lane_data_t;

  // size must already be clamped to the beat's log2 byte count by the caller
  function automatic lane_mask_t lane_mask(input logic [MAX_LO_W-1:0] addr_lo,
                                           input logic [MAX_SZ_W-1:0] size);
    int unsigned lo;
    int unsigned span;
    int unsigned hi;
    lane_mask_t  m;
    lo   = 32'(addr_lo);
    span = 32'd1 << size;
    hi   = (lo & ~(span - 32'd1)) + span;
    m    = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

  function automatic lane_data_t byte_expand(input lane_mask_t mask);
    lane_data_t d;
    d = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      d[8*i +: 8] = {8{mask[i]}};
    end
    return d;
  endfunction

endpackage

// File: rtl/asi_rmem_pipe.sv
// Generic N-stage valid+payload delay line; N==0 degenerates to a wire.
module asi_rmem_pipe #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  if (N == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign valid_o    = valid_i;
    assign data_o     = data_i;
  end else begin : g_reg
    logic [N-1:0] vld_q;
    logic [W-1:0] dat_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int unsigned i = 0; i < N; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= valid_i;
        dat_q[0] <= data_i;
        for (int unsigned i = 1; i < N; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign valid_o = vld_q[N-1];
    assign data_o  = dat_q[N-1];
  end

endmodule

// File: rtl/asi_rmem.sv
// User-clock SRAM read backend for the AXI slave read user port: fixed SLV_WS latency,
// lane masking, range check and sticky error status. Define ASI_RMEM_PARITY_EN for byte parity.
module asi_rmem
  import asi_pkg::*;
#(
  parameter int unsigned       AXI_DW    = 128,
  parameter int unsigned       AXI_AW    = 40,
  parameter int unsigned       AXI_SW    = 3,
  parameter int unsigned       SLV_WS    = 2,
  parameter int unsigned       RAM_LAT   = 1,
  parameter int unsigned       MEM_AW    = 10,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
  parameter int unsigned       ERRCW     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m_re,
  input  logic [AXI_AW-1:0]            m_raddr,
  input  logic [AXI_SW-1:0]            m_rsize,
  output logic [AXI_DW-1:0]            m_rdata,
  output logic                         m_rvalid,
  output logic                         m_rslverr,
  output logic                         sram_ce,
  output logic [MEM_AW-1:0]            sram_addr,
  input  logic [AXI_DW-1:0]            sram_q,
  input  logic [AXI_DW/8-1:0]          sram_par,
  input  logic                         err_clr,
  output logic [ERRCW-1:0]             err_cnt,
  output logic [AXI_AW-1:0]            err_addr,
  output logic                         err_vld,
  output logic [$clog2(SLV_WS+1)-1:0]  inflight
);

  localparam int unsigned SLV_BYTES = AXI_DW / 8;
  localparam int unsigned OFFW      = $clog2(SLV_BYTES);
  localparam int unsigned IFW       = $clog2(SLV_WS + 1);
  localparam int unsigned P1W       = SLV_BYTES + 1 + AXI_AW;
  localparam int unsigned P2W       = P1W + AXI_DW + 1;

  localparam logic [AXI_AW:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [AXI_AW:0] WIN_HI = WIN_LO + ((AXI_AW+1)'(1) << (OFFW + MEM_AW));

  if (SLV_WS < RAM_LAT) begin : g_chk_ws
    $error("asi_rmem: SLV_WS must be >= RAM_LAT");
  end
  if (RAM_LAT < 1) begin : g_chk_lat
    $error("asi_rmem: RAM_LAT must be >= 1");
  end
  if (BASE_ADDR[OFFW-1:0] != '0) begin : g_chk_base
    $error("asi_rmem: BASE_ADDR must be aligned to the beat width");
  end

  // ---------------------------------------------------------------- issue
  logic                 in_rng;
  logic [AXI_AW-1:0]    rel;
  logic [MAX_SZ_W-1:0]  sz_cl;
  logic [SLV_BYTES-1:0] iss_mask;

  assign in_rng    = ({1'b0, m_raddr} >= WIN_LO) && ({1'b0, m_raddr} < WIN_HI);
  assign sram_ce   = m_re && in_rng;
  assign rel       = m_raddr - BASE_ADDR;
  assign sram_addr = MEM_AW'(rel >> OFFW);

  // Mask is zero for idle cycles and out-of-range beats so the output needs no extra gating
  always_comb begin
    sz_cl    = (32'(m_rsize) > OFFW) ? MAX_SZ_W'(OFFW) : MAX_SZ_W'(m_rsize);
    iss_mask = '0;
    if (sram_ce) begin
      iss_mask = SLV_BYTES'(lane_mask(MAX_LO_W'(m_raddr[OFFW-1:0]), sz_cl));
    end
  end

  // ------------------------------------------------------- to RAM_LAT stage
  logic                 s1_vld;
  logic [P1W-1:0]       s1_data;
  logic [SLV_BYTES-1:0] s1_mask;
  logic                 s1_rng;
  logic [AXI_AW-1:0]    s1_addr;
  logic                 s1_perr;

  asi_rmem_pipe #(.N(RAM_LAT), .W(P1W)) u_pipe_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (m_re),
    .data_i  ({iss_mask, in_rng, m_raddr}),
    .valid_o (s1_vld),
    .data_o  (s1_data)
  );

  assign {s1_mask, s1_rng, s1_addr} = s1_data;

`ifdef ASI_RMEM_PARITY_EN
  always_comb begin
    s1_perr = 1'b0;
    for (int unsigned i = 0; i < SLV_BYTES; i++) begin
      s1_perr = s1_perr | (s1_mask[i] & ((^sram_q[8*i +: 8]) ^ sram_par[i]));
    end
  end
`else
  logic unused_par;
  assign unused_par = ^sram_par;
  assign s1_perr    = 1'b0;
`endif

  // ------------------------------------------------------- to SLV_WS stage
  logic                 s2_vld;
  logic [P2W-1:0]       s2_data;
  logic [SLV_BYTES-1:0] s2_mask;
  logic                 s2_rng;
  logic [AXI_AW-1:0]    s2_addr;
  logic [AXI_DW-1:0]    s2_q;
  logic                 s2_perr;

  asi_rmem_pipe #(.N(SLV_WS - RAM_LAT), .W(P2W)) u_pipe_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s1_vld),
    .data_i  ({s1_mask, s1_rng, s1_addr, sram_q, s1_perr}),
    .valid_o (s2_vld),
    .data_o  (s2_data)
  );

  assign {s2_mask, s2_rng, s2_addr, s2_q, s2_perr} = s2_data;

  assign m_rvalid  = s2_vld;
  assign m_rdata   = s2_q & AXI_DW'(byte_expand(MAX_BYTES'(s2_mask)));
  assign m_rslverr = s2_vld && (!s2_rng || s2_perr);

  // --------------------------------------------------------- status
  logic [IFW-1:0]    inflight_q, inflight_d;
  logic [ERRCW-1:0]  err_cnt_q, err_cnt_d;
  logic [AXI_AW-1:0] err_addr_q, err_addr_d;
  logic              err_vld_q, err_vld_d;

  always_comb begin
    inflight_d = inflight_q;
    if (m_re && !m_rvalid) begin
      inflight_d = inflight_q + IFW'(1);
    end else if (!m_re && m_rvalid) begin
      inflight_d = inflight_q - IFW'(1);
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_vld_d  = err_vld_q;
    if (err_clr) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
      err_vld_d  = 1'b0;
    end else if (m_rvalid && m_rslverr) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERRCW'(1);
      end
      if (!err_vld_q) begin
        err_addr_d = s2_addr;
        err_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_vld_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_vld_q  <= err_vld_d;
    end
  end

  assign inflight = inflight_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
  assign err_vld  = err_vld_q;

endmodule

// File: tb/tb_asi_rmem.sv
// Directed self-checking bench for asi_rmem (128-bit beats, SLV_WS=2, RAM_LAT=1, BASE 0x10000).
module tb_asi_rmem;

  localparam logic [39:0] BASE = 40'h10000;
`ifdef ASI_RMEM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_re = 1'b0;
  logic [39:0]  m_raddr = '0;
  logic [2:0]   m_rsize = '0;
  logic [127:0] m_rdata;
  logic         m_rvalid;
  logic         m_rslverr;
  logic         sram_ce;
  logic [9:0]   sram_addr;
  logic [127:0] sram_q = '0;
  logic [15:0]  sram_par;
  logic [15:0]  par_good;
  logic [15:0]  par_flip = '0;
  logic         err_clr = 1'b0;
  logic [7:0]   err_cnt;
  logic [39:0]  err_addr;
  logic         err_vld;
  logic [1:0]   inflight;

  logic [127:0] mem [1024];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  asi_rmem #(
    .AXI_DW(128), .AXI_AW(40), .AXI_SW(3), .SLV_WS(2), .RAM_LAT(1),
    .MEM_AW(10), .BASE_ADDR(BASE), .ERRCW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_re(m_re), .m_raddr(m_raddr), .m_rsize(m_rsize),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rslverr(m_rslverr),
    .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_q(sram_q), .sram_par(sram_par),
    .err_clr(err_clr), .err_cnt(err_cnt), .err_addr(err_addr), .err_vld(err_vld),
    .inflight(inflight)
  );

  // SRAM model: one-cycle read latency, even parity per byte with optional corruption
  always @(posedge clk) if (sram_ce) sram_q <= mem[sram_addr];
  always_comb begin
    par_good = '0;
    for (int i = 0; i < 16; i++) par_good[i] = ^sram_q[8*i +: 8];
  end
  assign sram_par = par_good ^ par_flip;

  function automatic logic [127:0] exp16(input logic [15:0] m);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = {8{m[i]}};
    return d;
  endfunction

  task automatic run_beat(input logic [39:0] a, input logic [2:0] s,
                          output logic ce, output logic [9:0] sa,
                          output logic [127:0] d, output logic e, output int lat);
    lat = -1; d = '0; e = 1'b0;
    @(negedge clk); m_re = 1'b1; m_raddr = a; m_rsize = s;
    #1; ce = sram_ce; sa = sram_addr;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); m_re = 1'b0;
      if (m_rvalid === 1'b1) begin lat = c; d = m_rdata; e = m_rslverr; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (m_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", m_rvalid); end
    tests++; if (m_rslverr !== 1'b0) begin fails++; $display("FAIL reset_slverr got %b want 0", m_rslverr); end
    tests++; if (m_rdata !== '0) begin fails++; $display("FAIL reset_rdata got %h want 0", m_rdata); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    tests++; if (err_vld !== 1'b0) begin fails++; $display("FAIL reset_err_vld got %b want 0", err_vld); end
    tests++; if (err_addr !== '0) begin fails++; $display("FAIL reset_err_addr got %h want 0", err_addr); end
    tests++; if (inflight !== 2'd0) begin fails++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    tests++; if (sram_ce !== 1'b0) begin fails++; $display("FAIL reset_sram_ce got %b want 0", sram_ce); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic ce; logic [9:0] sa; logic [127:0] d; logic e; int lat;
    run_beat(BASE + 40'h40, 3'd4, ce, sa, d, e, lat);
    tests++; if (ce !== 1'b1) begin fails++; $display("FAIL single_ce got %b want 1", ce); end
    tests++; if (sa !== 10'd4) begin fails++; $display("FAIL single_sram_addr got %0d want 4", sa); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL single_latency got %0d want 2", lat); end
    tests++; if (d !== {16{8'hA5}}) begin fails++; $display("FAIL single_data got %h want a5..", d); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL single_slverr got %b want 0", e); end
  endtask

  task automatic test_narrow();
    logic [7:0]  offs [5] = '{8'h03, 8'h06, 8'h05, 8'h09, 8'h0C};
    logic [2:0]  szs  [5] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd3};
    logic [15:0] msk  [5] = '{16'h0008, 16'h00C0, 16'h00E0, 16'hFE00, 16'hF000};
    logic ce; logic [9:0] sa; logic [127:0] d; logic e; int lat;
    for (int v = 0; v < 5; v++) begin
      run_beat(BASE + 40'h50 + 40'(offs[v]), szs[v], ce, sa, d, e, lat);
      tests++; if (d !== (mem[5] & exp16(msk[v])) || lat !== 2)
        begin fails++; $display("FAIL narrow_%0d data %h lat %0d want %h lat 2", v, d, lat, mem[5] & exp16(msk[v])); end
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL narrow_%0d_slverr got %b want 0", v, e); end
    end
  endtask

  task automatic test_back_to_back();
    int nv = 0, first = -1, last = -1, peak = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (m_rvalid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        if (nv < 16) begin
          tests++; if (m_rdata !== mem[nv]) begin fails++; $display("FAIL b2b_data_%0d got %h want %h", nv, m_rdata, mem[nv]); end
        end
        nv++;
      end
      if (int'(inflight) > peak) peak = int'(inflight);
      if (c < 16) begin m_re = 1'b1; m_raddr = BASE + 40'(c * 16); m_rsize = 3'd4; end
      else m_re = 1'b0;
    end
    tests++; if (nv !== 16) begin fails++; $display("FAIL b2b_count got %0d want 16", nv); end
    tests++; if (first !== 2 || last !== 17) begin fails++; $display("FAIL b2b_window got %0d..%0d want 2..17", first, last); end
    tests++; if (peak !== 2) begin fails++; $display("FAIL b2b_inflight_peak got %0d want 2", peak); end
    tests++; if (inflight !== 2'd0) begin fails++; $display("FAIL b2b_inflight_end got %0d want 0", inflight); end
  endtask

  task automatic test_range();
    logic ce; logic [9:0] sa; logic [127:0] d; logic e; int lat;
    run_beat(BASE + 40'h3FF0, 3'd4, ce, sa, d, e, lat);
    tests++; if (ce !== 1'b1 || sa !== 10'h3FF) begin fails++; $display("FAIL range_last ce %b addr %h want 1 3ff", ce, sa); end
    tests++; if (d !== mem[1023] || e !== 1'b0) begin fails++; $display("FAIL range_last_data %h err %b want %h 0", d, e, mem[1023]); end
    run_beat(BASE + 40'h4000, 3'd4, ce, sa, d, e, lat);
    tests++; if (ce !== 1'b0) begin fails++; $display("FAIL range_top_ce got %b want 0", ce); end
    tests++; if (d !== '0 || e !== 1'b1 || lat !== 2) begin fails++; $display("FAIL range_top data %h err %b lat %0d want 0 1 2", d, e, lat); end
    @(negedge clk);
    tests++; if (err_cnt !== 8'd1 || err_vld !== 1'b1) begin fails++; $display("FAIL range_err1 cnt %0d vld %b want 1 1", err_cnt, err_vld); end
    tests++; if (err_addr !== BASE + 40'h4000) begin fails++; $display("FAIL range_err_addr got %h want %h", err_addr, BASE + 40'h4000); end
    run_beat(BASE - 40'h10, 3'd4, ce, sa, d, e, lat);
    tests++; if (ce !== 1'b0 || e !== 1'b1) begin fails++; $display("FAIL range_below ce %b err %b want 0 1", ce, e); end
    @(negedge clk);
    tests++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL range_err2_cnt got %0d want 2", err_cnt); end
    tests++; if (err_addr !== BASE + 40'h4000) begin fails++; $display("FAIL range_err_addr_held got %h want %h", err_addr, BASE + 40'h4000); end
  endtask

  task automatic test_saturate_clear();
    logic seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); m_re = 1'b1; m_raddr = BASE + 40'h8000; m_rsize = 3'd4;
    end
    @(negedge clk); m_re = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL sat_cnt got %0d want 255", err_cnt); end
    @(negedge clk); m_re = 1'b1; m_raddr = BASE + 40'h8000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); m_re = 1'b0;
      if (m_rvalid === 1'b1) begin seen = 1'b1; break; end
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL clr_wait got no rvalid want rvalid within 8 cycles"); end
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    tests++; if (err_cnt !== 8'd0 || err_vld !== 1'b0 || err_addr !== '0)
      begin fails++; $display("FAIL clr_coincident cnt %0d vld %b addr %h want 0 0 0", err_cnt, err_vld, err_addr); end
    @(negedge clk);
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL clr_hold got %0d want 0", err_cnt); end
    @(negedge clk); m_re = 1'b1; m_raddr = BASE + 40'h9000;
    @(negedge clk); m_re = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (err_cnt !== 8'd1 || err_vld !== 1'b1 || err_addr !== BASE + 40'h9000)
      begin fails++; $display("FAIL clr_recapture cnt %0d vld %b addr %h want 1 1 %h", err_cnt, err_vld, err_addr, BASE + 40'h9000); end
  endtask

  task automatic test_parity();
    logic ce; logic [9:0] sa; logic [127:0] d; logic e; int lat;
    par_flip = 16'h0004;
    run_beat(BASE + 40'h40, 3'd4, ce, sa, d, e, lat);
    tests++; if (e !== PAR_EN) begin fails++; $display("FAIL parity_enabled_lane got %b want %b", e, PAR_EN); end
    tests++; if (d !== {16{8'hA5}}) begin fails++; $display("FAIL parity_data got %h want a5..", d); end
    run_beat(BASE + 40'h53, 3'd0, ce, sa, d, e, lat);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL parity_masked_lane got %b want 0", e); end
    par_flip = '0;
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    @(negedge clk); m_re = 1'b1; m_raddr = BASE; m_rsize = 3'd4;
    @(negedge clk); m_raddr = BASE + 40'h10;
    @(posedge clk); #1; m_re = 1'b0;
    tests++; if (inflight !== 2'd2) begin fails++; $display("FAIL rstmid_inflight_pre got %0d want 2", inflight); end
    rst_n = 1'b0; #1;
    tests++; if (m_rvalid !== 1'b0 || inflight !== 2'd0) begin fails++; $display("FAIL rstmid_async rvalid %b inflight %0d want 0 0", m_rvalid, inflight); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_rvalid === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid got pulse want none"); end
    tests++; if (inflight !== 2'd0 || err_cnt !== 8'd0) begin fails++; $display("FAIL rstmid_state inflight %0d cnt %0d want 0 0", inflight, err_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 1024; w++)
      for (int j = 0; j < 16; j++) mem[w][8*j +: 8] = 8'(w * 3 + j + 1);
    mem[4] = {16{8'hA5}};
    test_reset();
    test_single();
    test_narrow();
    test_back_to_back();
    test_range();
    test_saturate_clear();
    test_parity();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
